char_out_fifo: RTL

//  Buffered character-output device on the CPU main bus; successor to the single-char display port.
//  - CPU writes bytes with load_val; they queue in a DEPTH-entry FIFO.
//  - A drain FSM sends them to the serial/console sink over a valid/ready handshake, so the CPU never stalls on a slow sink.
//  - Status byte is readable back onto main_bus.

---
 rtl/cpu_io_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/char_out_fifo.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cpu_io_pkg.sv
// Shared definitions for CPU-side character I/O blocks: control characters,
// status byte bit positions and the drain FSM state encoding.
package cpu_io_pkg;

  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;

  // Bit positions inside the status byte; the low bits carry the occupancy count.
  localparam int STS_FULL  = 7;
  localparam int STS_OVF   = 6;
  localparam int STS_EMPTY = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    SEND_LF = 2'd2
  } drain_state_t;

  // First beat on the wire for a queued character when newline expansion is on:
  // a line feed goes out as carriage return first, everything else unchanged.
  function automatic logic [7:0] crlf_lead(input logic [7:0] ch);
    return (ch == CHAR_LF) ? CHAR_CR : ch;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a view of the two oldest entries,
// so the consumer can reload its output register back-to-back after a pop.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int BUS_W = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [BUS_W-1:0] wdata,
  output logic [BUS_W-1:0] head_data,
  output logic [BUS_W-1:0] second_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [BUS_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_plus1;
  logic [CNT_W-1:0] count_reg;

  assign rd_ptr_plus1 = rd_ptr_reg + PTR_W'(1);

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Pointers and count move together so a simultaneous push and pop is atomic.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_plus1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data   = mem[rd_ptr_reg];
  assign second_data = mem[rd_ptr_plus1];
  assign count       = count_reg;
  assign full        = (count_reg == CNT_W'(DEPTH));
  assign empty       = (count_reg == '0);

endmodule

// File: rtl/char_out_fifo.sv
// Buffered character output port. The CPU pushes bytes from main_bus, a drain
// FSM forwards them to the sink over valid/ready, and a status byte
// {full, ovf, empty, count} can be read back onto main_bus.
// Optional build macro CHAR_OUT_CRLF_EN: a queued line feed is sent as CR, LF.
module char_out_fifo
  import cpu_io_pkg::*;
#(
  parameter int BUS_W = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [BUS_W-1:0] main_bus,
  input  logic             load_val,
  input  logic             out_status,
  output logic [BUS_W-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  logic [BUS_W-1:0] head_data;
  logic [BUS_W-1:0] second_data;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             transfer;
  logic             more_after_pop;
  logic [BUS_W-1:0] next_byte;
  logic [BUS_W-1:0] status_byte;

  drain_state_t     state_reg, state_next;
  logic [BUS_W-1:0] tx_data_reg, tx_data_next;
  logic             tx_valid_reg, tx_valid_next;
  logic             ovf_reg, ovf_next;

  sync_fifo #(
    .DEPTH (DEPTH),
    .BUS_W (BUS_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .wdata       (main_bus),
    .head_data   (head_data),
    .second_data (second_data),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  // Beat value presented to the sink when an entry first reaches the head.
  function automatic logic [BUS_W-1:0] first_beat(input logic [BUS_W-1:0] ch);
`ifdef CHAR_OUT_CRLF_EN
    return crlf_lead(ch);
`else
    return ch;
`endif
  endfunction

  assign transfer = tx_valid_reg & tx_ready;

`ifdef CHAR_OUT_CRLF_EN
  // A line feed at the head stays queued through its CR beat; it pops on the LF beat.
  assign pop = transfer & ~((state_reg == SEND) & (head_data == CHAR_LF));
`else
  assign pop = transfer;
`endif

  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push = load_val & (~full | pop);

  // After a pop the next head is either already stored, or is the byte being
  // written this very edge (FIFO held exactly one entry), which is not in mem yet.
  assign more_after_pop = (count > CNT_W'(1)) | push;
  assign next_byte      = (count > CNT_W'(1)) ? second_data : main_bus;

  // Drain FSM next-state and registered-output logic.
  always_comb begin
    state_next    = state_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          tx_data_next  = first_beat(head_data);
          tx_valid_next = 1'b1;
          state_next    = SEND;
        end
      end
      SEND: begin
        if (pop) begin
          if (more_after_pop) begin
            tx_data_next = first_beat(next_byte);
            state_next   = SEND;
          end else begin
            tx_valid_next = 1'b0;
            state_next    = IDLE;
          end
`ifdef CHAR_OUT_CRLF_EN
        end else if (transfer) begin
          tx_data_next = CHAR_LF;
          state_next   = SEND_LF;
`endif
        end
      end
`ifdef CHAR_OUT_CRLF_EN
      SEND_LF: begin
        if (pop) begin
          if (more_after_pop) begin
            tx_data_next = first_beat(next_byte);
            state_next   = SEND;
          end else begin
            tx_valid_next = 1'b0;
            state_next    = IDLE;
          end
        end
      end
`endif
      default: begin
        tx_valid_next = 1'b0;
        state_next    = IDLE;
      end
    endcase
  end

  // Overflow is sticky; a status read clears it, but a new drop on the same edge wins.
  always_comb begin
    ovf_next = ovf_reg;
    if (out_status) ovf_next = 1'b0;
    if (load_val & full & ~pop) ovf_next = 1'b1;
  end

  // State, output and flag registers; reset abandons any character in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      ovf_reg      <= ovf_next;
    end
  end

  // Status byte assembly: flags on top, occupancy count in the low bits.
  always_comb begin
    status_byte            = '0;
    status_byte[CNT_W-1:0] = count;
    status_byte[STS_FULL]  = full;
    status_byte[STS_OVF]   = ovf_reg;
    status_byte[STS_EMPTY] = empty;
  end

  assign main_bus = out_status ? status_byte : {BUS_W{1'bz}};
  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;

endmodule
